// File: rtl/parking_display.sv
// Downstream display stage of the parking counter: free spaces = CAPACITY - count,
// serial double-dabble BCD conversion, 3-digit multiplexed 7-segment scan and lot flags.
module parking_display #(
  parameter int unsigned CAPACITY    = 200,
  parameter int unsigned REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] count,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       full,
  output logic       empty,
  output logic       over,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] CAP8 = 8'(CAPACITY);
  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  last_cnt_q, last_cnt_d;
  logic [7:0]  smp_q, smp_d;
  logic        pend_q, pend_d;
  logic [7:0]  sh_q, sh_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [3:0]  disp_h_q, disp_h_d, disp_t_q, disp_t_d, disp_u_q, disp_u_d;
  logic [PW-1:0] presc_q;
  logic [1:0]  idx_q;
  logic [6:0]  seg_q, seg_sel;
  logic [2:0]  an_q;
  logic        full_q, empty_q, over_q, busy_q;
  logic [8:0]  diff;
  logic [7:0]  free_val;
  logic [11:0] adj;

  function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
    dd_adjust = (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  // Borrow out of the 9-bit subtraction means the lot is over capacity.
  assign diff     = {1'b0, CAP8} - {1'b0, smp_q};
  assign free_val = diff[8] ? 8'd0 : diff[7:0];
  assign adj      = {dd_adjust(bcd_q[11:8]), dd_adjust(bcd_q[7:4]), dd_adjust(bcd_q[3:0])};

  always_comb begin
    state_d    = state_q;
    last_cnt_d = last_cnt_q;
    smp_d      = smp_q;
    pend_d     = pend_q | (count != last_cnt_q);
    sh_d       = sh_q;
    bcd_d      = bcd_q;
    bitcnt_d   = bitcnt_q;
    disp_h_d   = disp_h_q;
    disp_t_d   = disp_t_q;
    disp_u_d   = disp_u_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          smp_d      = count;
          last_cnt_d = count;
          pend_d     = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        sh_d     = free_val;
        bcd_d    = 12'd0;
        bitcnt_d = 3'd0;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        bcd_d    = {adj[10:0], sh_q[7]};
        sh_d     = {sh_q[6:0], 1'b0};
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        disp_h_d = bcd_q[11:8];
        disp_t_d = bcd_q[7:4];
        disp_u_d = bcd_q[3:0];
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_cnt_q <= 8'd0;
      smp_q      <= 8'd0;
      pend_q     <= 1'b1;
      sh_q       <= 8'd0;
      bcd_q      <= 12'd0;
      bitcnt_q   <= 3'd0;
      disp_h_q   <= 4'd0;
      disp_t_q   <= 4'd0;
      disp_u_q   <= 4'd0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_cnt_q <= last_cnt_d;
      smp_q      <= smp_d;
      pend_q     <= pend_d;
      sh_q       <= sh_d;
      bcd_q      <= bcd_d;
      bitcnt_q   <= bitcnt_d;
      disp_h_q   <= disp_h_d;
      disp_t_q   <= disp_t_d;
      disp_u_q   <= disp_u_d;
      busy_q     <= (state_d != ST_IDLE);
      full_q     <= (count >= CAP8);
      empty_q    <= (count == 8'd0);
      over_q     <= (count > CAP8);
    end
  end

  // Leading-zero blanking: hundreds and tens go dark when they carry no information.
  always_comb begin
    seg_sel = 7'h7F;
    case (idx_q)
      2'd0: seg_sel = seg_decode(disp_u_q);
      2'd1: begin
        if ((disp_h_q == 4'd0) && (disp_t_q == 4'd0)) begin
          seg_sel = 7'h7F;
        end else begin
          seg_sel = seg_decode(disp_t_q);
        end
      end
      2'd2: begin
        if (disp_h_q == 4'd0) begin
          seg_sel = 7'h7F;
        end else begin
          seg_sel = seg_decode(disp_h_q);
        end
      end
      default: seg_sel = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      an_q    <= 3'b111;
      seg_q   <= 7'h7F;
    end else begin
      an_q  <= ~(3'b001 << idx_q);
      seg_q <= seg_sel;
      if (presc_q == PRESC_MAX) begin
        presc_q <= '0;
        idx_q   <= (idx_q == 2'd2) ? 2'd0 : (idx_q + 2'd1);
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign over  = over_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_parking_display.sv
// Bench for parking_display: cycle-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_parking_display;
  localparam int CAP = 200;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] count;
  logic [6:0] seg;
  logic [2:0] an;
  logic       full, empty, over, busy;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  parking_display #(.CAPACITY(CAP), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .count(count), .seg(seg), .an(an),
    .full(full), .empty(empty), .over(over), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  // Reference model: a conversion is a fixed 10-cycle window; the displayed number is plain arithmetic.
  int m_last, m_smp, m_disp, m_phase, m_idx, m_presc;
  bit m_pend, m_full, m_empty, m_over, m_busy;
  logic [6:0] m_seg;
  logic [2:0] m_an;

  always @(posedge clk) begin
    if (reset) begin
      m_last = 0; m_smp = 0; m_disp = 0; m_phase = 0; m_idx = 0; m_presc = 0;
      m_pend = 1'b1; m_full = 1'b0; m_empty = 1'b1; m_over = 1'b0; m_busy = 1'b0;
      m_seg = 7'h7F; m_an = 3'b111;
    end else begin
      int h, t, u;
      h = m_disp / 100; t = (m_disp / 10) % 10; u = m_disp % 10;
      m_an = ~(3'b001 << m_idx);
      if (m_idx == 0) m_seg = seg_of(u);
      else if (m_idx == 1) m_seg = (h == 0 && t == 0) ? 7'h7F : seg_of(t);
      else m_seg = (h == 0) ? 7'h7F : seg_of(h);
      if (m_presc == DIV - 1) begin
        m_presc = 0;
        m_idx = (m_idx + 1) % 3;
      end else begin
        m_presc++;
      end
      m_full  = (int'(count) >= CAP);
      m_empty = (count == 8'd0);
      m_over  = (int'(count) > CAP);
      if (m_phase == 0) begin
        if (m_pend) begin
          m_smp = count; m_last = count; m_pend = 1'b0; m_phase = 1;
        end else begin
          m_pend = (int'(count) != m_last);
        end
      end else begin
        m_pend = m_pend | (int'(count) != m_last);
        if (m_phase == 10) begin
          m_disp = (m_smp > CAP) ? 0 : CAP - m_smp;
          m_phase = 0;
        end else begin
          m_phase++;
        end
      end
      m_busy = (m_phase != 0);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_seg", {5'd0, seg}, {5'd0, m_seg});
      chk("mon_an", {9'd0, an}, {9'd0, m_an});
      chk("mon_full", {11'd0, full}, {11'd0, m_full});
      chk("mon_empty", {11'd0, empty}, {11'd0, m_empty});
      chk("mon_over", {11'd0, over}, {11'd0, m_over});
      chk("mon_busy", {11'd0, busy}, {11'd0, m_busy});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_an(input logic [2:0] target, input string name);
    for (int k = 0; k < 30; k++) begin
      if (an == target) break;
      step(1);
    end
    chk(name, {9'd0, an}, {9'd0, target});
  endtask

  initial begin
    // 1: reset state, then "200"
    reset = 1'b1; count = 8'd0;
    step(2);
    mon_en = 1'b1;
    chk("rst_seg", {5'd0, seg}, 12'h07F);
    chk("rst_an", {9'd0, an}, 12'h007);
    chk("rst_empty", {11'd0, empty}, 12'h001);
    chk("rst_full", {11'd0, full}, 12'h000);
    chk("rst_busy", {11'd0, busy}, 12'h000);
    reset = 1'b0;
    step(14);
    wait_an(3'b011, "t1_an_h");
    chk("t1_hund_2", {5'd0, seg}, 12'h024);
    wait_an(3'b110, "t1_an_u");
    chk("t1_units_0", {5'd0, seg}, 12'h040);

    // 2: 0 -> 5, latency window
    count = 8'd5;
    step(1);
    chk("t2_empty_n1", {11'd0, empty}, 12'h000);
    chk("t2_busy_n1", {11'd0, busy}, 12'h000);
    step(1);
    chk("t2_busy_n2", {11'd0, busy}, 12'h001);
    step(9);
    chk("t2_busy_n11", {11'd0, busy}, 12'h001);
    step(1);
    chk("t2_busy_n12", {11'd0, busy}, 12'h000);
    step(1);
    wait_an(3'b110, "t2_an_u");
    chk("t2_units_5", {5'd0, seg}, 12'h012);
    wait_an(3'b101, "t2_an_t");
    chk("t2_tens_9", {5'd0, seg}, 12'h010);
    wait_an(3'b011, "t2_an_h");
    chk("t2_hund_1", {5'd0, seg}, 12'h079);

    // 3: exactly full, then over
    count = 8'd200;
    step(15);
    chk("t3_full", {11'd0, full}, 12'h001);
    chk("t3_over", {11'd0, over}, 12'h000);
    wait_an(3'b011, "t3_an_h");
    chk("t3_hund_blank", {5'd0, seg}, 12'h07F);
    wait_an(3'b110, "t3_an_u");
    chk("t3_units_0", {5'd0, seg}, 12'h040);
    wait_an(3'b101, "t3_an_t");
    chk("t3_tens_blank", {5'd0, seg}, 12'h07F);
    count = 8'd203;
    step(1);
    chk("t3_over_set", {11'd0, over}, 12'h001);
    step(15);
    wait_an(3'b110, "t3b_an_u");
    chk("t3b_units_0", {5'd0, seg}, 12'h040);

    // 4: back-to-back changes while busy
    count = 8'd10; step(1);
    count = 8'd11; step(1);
    count = 8'd12;
    step(30);
    chk("t4_idle", {11'd0, busy}, 12'h000);
    wait_an(3'b110, "t4_an_u");
    chk("t4_units_8", {5'd0, seg}, 12'h000);
    wait_an(3'b011, "t4_an_h");
    chk("t4_hund_1", {5'd0, seg}, 12'h079);

    // 5: scan cadence for "195"
    count = 8'd5;
    step(15);
    wait_an(3'b011, "t5_sync_h");
    wait_an(3'b110, "t5_sync_u");
    for (int i = 0; i < 2 * 3 * DIV; i++) begin
      logic [2:0] exp_an;
      exp_an = ((i % 12) < 4) ? 3'b110 : (((i % 12) < 8) ? 3'b101 : 3'b011);
      chk("t5_scan_an", {9'd0, an}, {9'd0, exp_an});
      if (exp_an == 3'b110) chk("t5_scan_units", {5'd0, seg}, 12'h012);
      step(1);
    end

    // 6: reset mid-conversion, then reconvert 77 -> "123"
    count = 8'd77;
    step(4);
    chk("t6_busy_pre", {11'd0, busy}, 12'h001);
    reset = 1'b1;
    step(1);
    chk("t6_busy_rst", {11'd0, busy}, 12'h000);
    chk("t6_seg_rst", {5'd0, seg}, 12'h07F);
    chk("t6_an_rst", {9'd0, an}, 12'h007);
    reset = 1'b0;
    step(20);
    wait_an(3'b110, "t6_an_u");
    chk("t6_units_3", {5'd0, seg}, 12'h030);
    wait_an(3'b101, "t6_an_t");
    chk("t6_tens_2", {5'd0, seg}, 12'h024);
    wait_an(3'b011, "t6_an_h");
    chk("t6_hund_1", {5'd0, seg}, 12'h079);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
